// File: rtl/s832_bist_pkg.sv
// Shared types and constants for the s832 self-test controller.
// Holds the controller states, generator/compactor widths and fixed patterns.
package s832_bist_pkg;

    localparam int LFSR_W   = 18;
    localparam int MISR_W   = 19;
    localparam int LFSR_TAP = 10;

    localparam logic [MISR_W-1:0] MISR_POLY  = 19'h00027;
    localparam logic [LFSR_W-1:0] CLEAR_STIM = 18'h20000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_t;

    // Fibonacci step for x^18 + x^11 + 1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_TAP]};
    endfunction

endpackage

// File: rtl/s832_misr.sv
// 19-bit Galois MISR (x^19 + x^5 + x^2 + x + 1) with synchronous clear and enable.
// Generic enough to compact the outputs of any wrapped benchmark circuit.
module s832_misr
    import s832_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] feedback;

    assign feedback = sig[MISR_W-1] ? MISR_POLY : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[MISR_W-2:0], 1'b0} ^ feedback ^ din;
        end
    end

endmodule

// File: rtl/s832_bist.sv
// BIST controller for s832: clears the CUT through G18, drives N_PAT LFSR
// patterns and compacts the responses into a MISR signature checked on DONE.
module s832_bist
    import s832_bist_pkg::*;
#(
    parameter int                N_PAT       = 1024,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 18'h00001,
    parameter logic [MISR_W-1:0] MISR_GOLDEN = 19'h00000
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [MISR_W-1:0] SIG,
    output logic [LFSR_W-1:0] STIM,
    input  logic [MISR_W-1:0] RESP
);

    localparam int                CNT_W    = $clog2(N_PAT + 1);
    localparam logic [LFSR_W-1:0] SEED     = (LFSR_SEED == '0) ? 18'h00001 : LFSR_SEED;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_PAT - 1);

    state_t            state;
    state_t            next_state;
    logic [LFSR_W-1:0] lfsr;
    logic [CNT_W-1:0]  count;
    logic              in_clear;
    logic              in_run;

    assign in_clear = (state == ST_CLEAR);
    assign in_run   = (state == ST_RUN);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        STIM       = '0;
        unique case (state)
            ST_IDLE: begin
                if (START) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                STIM       = CLEAR_STIM;
                next_state = ST_RUN;
            end
            ST_RUN: begin
                // G18 stays low so the CUT is never reset mid-run.
                STIM = {1'b0, lfsr[LFSR_W-2:0]};
                if (count == LAST_IDX) next_state = ST_DONE;
            end
            ST_DONE: begin
                if (START) next_state = ST_CLEAR;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            lfsr  <= SEED;
            count <= '0;
        end else if (in_clear) begin
            lfsr  <= SEED;
            count <= '0;
        end else if (in_run) begin
            lfsr  <= lfsr_next(lfsr);
            count <= count + 1'b1;
        end
    end

    // RESP belongs to the pattern presented this cycle, so it is absorbed on
    // the same edge that advances the generator.
    s832_misr u_misr (
        .clk   (CK),
        .rst_n (RN),
        .clear (in_clear),
        .en    (in_run),
        .din   (RESP),
        .sig   (SIG)
    );

    assign BUSY = in_clear || in_run;
    assign DONE = (state == ST_DONE);
    assign PASS = DONE && (SIG == MISR_GOLDEN);

endmodule

// File: tb/tb_s832_bist.sv
// Directed bench for s832_bist: several instances with different parameters
// share clock, reset and START, and are compared against hand-computed values.
module tb_s832_bist;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        START = 1'b0;
    logic [18:0] resp_zero = 19'h00000;
    logic [18:0] resp_one  = 19'h00001;

    logic        a_busy, a_done, a_pass;
    logic [18:0] a_sig;
    logic [17:0] a_stim;
    logic        b_busy, b_done, b_pass;
    logic [18:0] b_sig;
    logic [17:0] b_stim;
    logic        c_busy, c_done, c_pass;
    logic [18:0] c_sig;
    logic [17:0] c_stim;
    logic        d_busy, d_done, d_pass;
    logic [18:0] d_sig;
    logic [17:0] d_stim;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    s832_bist #(.N_PAT(16), .LFSR_SEED(18'h00001), .MISR_GOLDEN(19'h00000)) u_a (
        .CK(CK), .RN(RN), .START(START), .BUSY(a_busy), .DONE(a_done),
        .PASS(a_pass), .SIG(a_sig), .STIM(a_stim), .RESP(resp_zero));

    s832_bist #(.N_PAT(2), .LFSR_SEED(18'h00001), .MISR_GOLDEN(19'h00003)) u_b (
        .CK(CK), .RN(RN), .START(START), .BUSY(b_busy), .DONE(b_done),
        .PASS(b_pass), .SIG(b_sig), .STIM(b_stim), .RESP(resp_one));

    s832_bist #(.N_PAT(2), .LFSR_SEED(18'h00001), .MISR_GOLDEN(19'h00004)) u_c (
        .CK(CK), .RN(RN), .START(START), .BUSY(c_busy), .DONE(c_done),
        .PASS(c_pass), .SIG(c_sig), .STIM(c_stim), .RESP(resp_one));

    s832_bist #(.N_PAT(2), .LFSR_SEED(18'h00000), .MISR_GOLDEN(19'h00000)) u_d (
        .CK(CK), .RN(RN), .START(START), .BUSY(d_busy), .DONE(d_done),
        .PASS(d_pass), .SIG(d_sig), .STIM(d_stim), .RESP(resp_zero));

    typedef struct {
        logic        busy;
        logic        done;
        logic        pass;
        logic [17:0] stim;
    } vec_t;

    vec_t        tab [19];
    logic [17:0] run_stim [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // START high for one cycle; returns at the negedge after the sampling edge.
    task automatic pulse_start();
        START = 1'b1;
        @(posedge CK);
        @(negedge CK);
        START = 1'b0;
    endtask

    initial begin
        int idx;

        // Index 0 is the CLEAR cycle, 1..16 the RUN cycles, 17..18 DONE.
        run_stim = '{18'h00001, 18'h00002, 18'h00004, 18'h00008,
                     18'h00010, 18'h00020, 18'h00040, 18'h00080,
                     18'h00100, 18'h00200, 18'h00400, 18'h00801,
                     18'h01002, 18'h02004, 18'h04008, 18'h08010};
        tab[0] = '{busy: 1'b1, done: 1'b0, pass: 1'b0, stim: 18'h20000};
        for (int i = 1; i <= 16; i++)
            tab[i] = '{busy: 1'b1, done: 1'b0, pass: 1'b0, stim: run_stim[i-1]};
        tab[17] = '{busy: 1'b0, done: 1'b1, pass: 1'b1, stim: 18'h00000};
        tab[18] = '{busy: 1'b0, done: 1'b1, pass: 1'b1, stim: 18'h00000};

        // Reset state
        repeat (2) @(negedge CK);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_pass", 32'(a_pass), 32'd0);
        check("rst_stim", 32'(a_stim), 32'd0);
        check("rst_sig",  32'(a_sig),  32'd0);
        RN = 1'b1;
        repeat (2) @(negedge CK);
        check("idle_busy", 32'(a_busy), 32'd0);

        // Full run compared cycle by cycle against the table
        pulse_start();
        for (int i = 0; i < 19; i++) begin
            check($sformatf("busy[%0d]", i), 32'(a_busy), 32'(tab[i].busy));
            check($sformatf("done[%0d]", i), 32'(a_done), 32'(tab[i].done));
            check($sformatf("pass[%0d]", i), 32'(a_pass), 32'(tab[i].pass));
            check($sformatf("stim[%0d]", i), 32'(a_stim), 32'(tab[i].stim));
            if (i == 1) check("seed0_stim", 32'(d_stim), 32'h00001);
            if (i == 3) begin
                check("n2_done",     32'(b_done), 32'd1);
                check("n2_sig",      32'(b_sig),  32'h00003);
                check("n2_pass_g3",  32'(b_pass), 32'd1);
                check("n2_pass_g4",  32'(c_pass), 32'd0);
                check("n2_done_g4",  32'(c_done), 32'd1);
            end
            if (i == 17) check("n16_sig", 32'(a_sig), 32'd0);
            @(negedge CK);
        end

        // START in CLEAR (idx 0) and RUN (idx 5) must not disturb DONE timing
        START = 1'b1;
        @(posedge CK);
        @(negedge CK);
        idx = 0;
        while (!a_done && idx < 60) begin
            START = (idx == 0 || idx == 5);
            @(negedge CK);
            idx++;
        end
        START = 1'b0;
        check("done_latency", 32'(idx), 32'd17);

        // START on the first DONE cycle restarts at once
        check("first_done", 32'(a_done), 32'd1);
        START = 1'b1;
        @(posedge CK);
        @(negedge CK);
        START = 1'b0;
        check("restart_done", 32'(a_done), 32'd0);
        check("restart_busy", 32'(a_busy), 32'd1);
        check("restart_stim", 32'(a_stim), 32'h20000);
        idx = 0;
        while (!a_done && idx < 60) begin
            @(negedge CK);
            idx++;
        end
        check("rerun_latency", 32'(idx), 32'd17);
        check("rerun_sig_b",   32'(b_sig),  32'h00003);
        check("rerun_pass_b",  32'(b_pass), 32'd1);

        // Asynchronous reset in the middle of RUN
        pulse_start();
        repeat (4) @(negedge CK);
        check("pre_rst_busy", 32'(a_busy), 32'd1);
        check("pre_rst_sig_b", 32'(b_sig), 32'h00003);
        #2 RN = 1'b0;
        #1;
        check("arst_busy",  32'(a_busy), 32'd0);
        check("arst_done",  32'(b_done), 32'd0);
        check("arst_pass",  32'(b_pass), 32'd0);
        check("arst_stim",  32'(a_stim), 32'd0);
        check("arst_sig",   32'(b_sig),  32'd0);
        @(negedge CK);
        RN = 1'b1;
        repeat (3) @(negedge CK);
        check("post_rst_busy", 32'(a_busy), 32'd0);
        check("post_rst_done", 32'(a_done), 32'd0);
        check("post_rst_stim", 32'(a_stim), 32'd0);

        // Generator restarts from the seed after reset
        pulse_start();
        check("post_rst_clear", 32'(a_stim), 32'h20000);
        @(negedge CK);
        check("post_rst_seed", 32'(a_stim), 32'h00001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
